// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use stall, redirect/jump flush and youngest-wins operand forwarding over NSTG post-ID stages
module pipe_hazard_ctrl #(
    parameter int NSTG = 3,
    parameter int RAW = 5,
    parameter int LOAD_STG = 1,
    localparam int FSW = $clog2(NSTG)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            id_valid,
    input  logic [RAW-1:0]  id_rs,
    input  logic [RAW-1:0]  id_rt,
    input  logic            id_rs_used,
    input  logic            id_rt_used,
    input  logic [RAW-1:0]  id_dst,
    input  logic            id_regwrite,
    input  logic            id_memread,
    input  logic            id_jump,
    input  logic            ex_redirect,
    output logic            pc_we,
    output logic            ifid_we,
    output logic            ifid_flush,
    output logic            idex_bubble,
    output logic [FSW-1:0]  fwd_a,
    output logic [FSW-1:0]  fwd_b,
    output logic [NSTG-1:0] stage_valid,
    output logic [31:0]     stall_cnt
);
    logic [NSTG-1:0] v;
    logic            rw    [NSTG];
    logic            mr    [NSTG];
    logic [RAW-1:0]  rs_q  [NSTG];
    logic [RAW-1:0]  rt_q  [NSTG];
    logic [RAW-1:0]  dst_q [NSTG];
    logic [31:0]     cnt;
    logic            redir, stall, load_hit, rs_hot, rt_hot;

    assign redir       = ex_redirect & v[0];
    assign rs_hot      = id_rs_used & (id_rs != '0);
    assign rt_hot      = id_rt_used & (id_rt != '0);
    assign stall       = id_valid & ~redir & load_hit;
    assign pc_we       = ~stall | redir;
    assign ifid_we     = pc_we;
    assign idex_bubble = stall | redir;
    assign ifid_flush  = redir | (id_jump & id_valid & ~stall);
    assign stage_valid = v;
    assign stall_cnt   = cnt;

    always_comb begin
        load_hit = 1'b0;
        for (int s = 0; s < LOAD_STG; s++)
            load_hit = load_hit | (v[s] & mr[s] & (dst_q[s] != '0) &
                       ((rs_hot & (dst_q[s] == id_rs)) | (rt_hot & (dst_q[s] == id_rt))));
    end

    // descending scan so the youngest matching stage is the last writer
    always_comb begin
        fwd_a = '0;
        fwd_b = '0;
        for (int k = NSTG - 1; k >= 1; k--) begin
            if (v[0] && v[k] && rw[k] && dst_q[k] != '0 && dst_q[k] == rs_q[0]) fwd_a = FSW'(k);
            if (v[0] && v[k] && rw[k] && dst_q[k] != '0 && dst_q[k] == rt_q[0]) fwd_b = FSW'(k);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v   <= '0;
            cnt <= '0;
            for (int k = 0; k < NSTG; k++) begin
                rw[k]    <= 1'b0;
                mr[k]    <= 1'b0;
                rs_q[k]  <= '0;
                rt_q[k]  <= '0;
                dst_q[k] <= '0;
            end
        end else begin
            v        <= {v[NSTG-2:0], id_valid & ~stall & ~redir};
            rw[0]    <= id_regwrite;
            mr[0]    <= id_memread;
            rs_q[0]  <= id_rs;
            rt_q[0]  <= id_rt;
            dst_q[0] <= id_dst;
            for (int k = 1; k < NSTG; k++) begin
                rw[k]    <= rw[k-1];
                mr[k]    <= mr[k-1];
                rs_q[k]  <= rs_q[k-1];
                rt_q[k]  <= rt_q[k-1];
                dst_q[k] <= dst_q[k-1];
            end
            if (stall && cnt != '1) cnt <= cnt + 32'd1;
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed and random checks of two configurations against an instruction-level pipeline model
module tb_pipe_hazard_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic id_valid, id_rs_used, id_rt_used, id_regwrite, id_memread, id_jump, ex_redirect;
    logic [4:0] id_rs, id_rt, id_dst;
    logic pc3, ifwe3, fl3, bb3, pc5, ifwe5, fl5, bb5;
    logic [1:0] fa3, fb3;
    logic [2:0] fa5, fb5, sv3;
    logic [4:0] sv5;
    logic [31:0] cnt3, cnt5;
    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.NSTG(3), .RAW(5), .LOAD_STG(1)) dut3 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_dst(id_dst),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .id_jump(id_jump),
        .ex_redirect(ex_redirect), .pc_we(pc3), .ifid_we(ifwe3), .ifid_flush(fl3),
        .idex_bubble(bb3), .fwd_a(fa3), .fwd_b(fb3), .stage_valid(sv3), .stall_cnt(cnt3)
    );

    pipe_hazard_ctrl #(.NSTG(5), .RAW(5), .LOAD_STG(2)) dut5 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_dst(id_dst),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .id_jump(id_jump),
        .ex_redirect(ex_redirect), .pc_we(pc5), .ifid_we(ifwe5), .ifid_flush(fl5),
        .idex_bubble(bb5), .fwd_a(fa5), .fwd_b(fb5), .stage_valid(sv5), .stall_cnt(cnt5)
    );

    typedef struct packed {
        logic v;
        logic [4:0] rs, rt, dst;
        logic rw, mr;
    } ins_t;

    typedef struct packed {
        logic stall, redir, pc_we, flush, bubble;
        logic [2:0] fa, fb;
        logic [4:0] sv;
    } exp_t;

    ins_t m3 [5];
    ins_t m5 [5];
    logic [31:0] c3, c5, base5;

    // Instruction-level view: an in-flight load whose data is not ready yet blocks a hot reader,
    // and EX takes the value of the most recent older writer of its source register.
    function automatic exp_t predict(input ins_t p [5], input int n, input int ld);
        exp_t e;
        logic hit;
        e = '0;
        hit = 1'b0;
        e.redir = ex_redirect & p[0].v;
        for (int s = 0; s < ld; s++)
            if (p[s].v && p[s].mr && p[s].dst != 0 &&
                ((id_rs_used && id_rs != 0 && id_rs == p[s].dst) ||
                 (id_rt_used && id_rt != 0 && id_rt == p[s].dst))) hit = 1'b1;
        e.stall  = id_valid & ~e.redir & hit;
        e.pc_we  = ~e.stall | e.redir;
        e.bubble = e.stall | e.redir;
        e.flush  = e.redir | (id_jump & id_valid & ~e.stall);
        for (int k = n - 1; k >= 1; k--) begin
            if (p[0].v && p[k].v && p[k].rw && p[k].dst != 0 && p[k].dst == p[0].rs) e.fa = 3'(k);
            if (p[0].v && p[k].v && p[k].rw && p[k].dst != 0 && p[k].dst == p[0].rt) e.fb = 3'(k);
        end
        for (int k = 0; k < n; k++) e.sv[k] = p[k].v;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_models();
        for (int k = 0; k < 5; k++) begin
            m3[k] = '0;
            m5[k] = '0;
        end
        c3 = '0;
        c5 = '0;
    endtask

    // Called just after a falling edge with ID inputs driven; returns at the next falling edge.
    task automatic step(input string tag);
        exp_t e3, e5;
        ins_t cur;
        #1;
        e3 = predict(m3, 3, 1);
        e5 = predict(m5, 5, 2);
        chk({tag, ".pc3"}, pc3, e3.pc_we);
        chk({tag, ".ifwe3"}, ifwe3, e3.pc_we);
        chk({tag, ".flush3"}, fl3, e3.flush);
        chk({tag, ".bub3"}, bb3, e3.bubble);
        chk({tag, ".fa3"}, fa3, e3.fa);
        chk({tag, ".fb3"}, fb3, e3.fb);
        chk({tag, ".sv3"}, sv3, e3.sv);
        chk({tag, ".cnt3"}, cnt3, c3);
        chk({tag, ".pc5"}, pc5, e5.pc_we);
        chk({tag, ".ifwe5"}, ifwe5, e5.pc_we);
        chk({tag, ".flush5"}, fl5, e5.flush);
        chk({tag, ".bub5"}, bb5, e5.bubble);
        chk({tag, ".fa5"}, fa5, e5.fa);
        chk({tag, ".fb5"}, fb5, e5.fb);
        chk({tag, ".sv5"}, sv5, e5.sv);
        chk({tag, ".cnt5"}, cnt5, c5);
        @(posedge clk);
        cur = '{v: id_valid, rs: id_rs, rt: id_rt, dst: id_dst, rw: id_regwrite, mr: id_memread};
        for (int k = 4; k >= 1; k--) begin
            m3[k] = m3[k-1];
            m5[k] = m5[k-1];
        end
        m3[0] = cur;
        m5[0] = cur;
        m3[0].v = id_valid & ~e3.stall & ~e3.redir;
        m5[0].v = id_valid & ~e5.stall & ~e5.redir;
        if (e3.stall && c3 != '1) c3 = c3 + 1;
        if (e5.stall && c5 != '1) c5 = c5 + 1;
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input int rs, input int rt, input logic ru, input logic tu,
                         input int dst, input logic rw, input logic mr, input logic j, input logic rd);
        id_valid = v;
        id_rs = 5'(rs);
        id_rt = 5'(rt);
        id_rs_used = ru;
        id_rt_used = tu;
        id_dst = 5'(dst);
        id_regwrite = rw;
        id_memread = mr;
        id_jump = j;
        ex_redirect = rd;
    endtask

    task automatic alu(input int d, input int a, input int b);
        drive(1, a, b, 1, 1, d, 1, 0, 0, 0);
    endtask

    task automatic ld(input int d, input int a);
        drive(1, a, 0, 1, 0, d, 1, 1, 0, 0);
    endtask

    task automatic nop();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic drain();
        nop();
        repeat (6) step("drain");
    endtask

    initial begin
        clear_models();
        nop();
        repeat (2) @(negedge clk);
        #1;
        chk("rst.sv3", sv3, 0);
        chk("rst.sv5", sv5, 0);
        chk("rst.pc3", pc3, 1);
        chk("rst.fa3", fa3, 0);
        chk("rst.fb3", fb3, 0);
        chk("rst.cnt3", cnt3, 0);
        @(negedge clk);
        reset = 1'b0;

        alu(3, 1, 2); step("t1a");
        alu(4, 3, 5); step("t1b");
        nop(); #1; chk("t1.fwd_mem", fa3, 1); step("t1c");
        drain();
        alu(3, 1, 2); step("t1d");
        alu(7, 8, 9); step("t1e");
        alu(4, 3, 5); step("t1f");
        nop(); #1; chk("t1.fwd_wb", fa3, 2); step("t1g");
        drain();

        ld(3, 1); step("t2a");
        alu(6, 3, 3); #1;
        chk("t2.pc_stall", pc3, 0);
        chk("t2.ifwe_stall", ifwe3, 0);
        chk("t2.bub_stall", bb3, 1);
        step("t2b");
        #1;
        chk("t2.cnt1", cnt3, 1);
        chk("t2.pc_resume", pc3, 1);
        step("t2c");
        nop(); #1;
        chk("t2.fa_wb", fa3, 2);
        chk("t2.fb_wb", fb3, 2);
        step("t2d");
        drain();

        alu(3, 1, 1); step("t3a");
        alu(3, 2, 2); step("t3b");
        alu(5, 3, 0); step("t3c");
        nop(); #1; chk("t3.youngest", fa3, 1); step("t3d");
        drain();
        alu(0, 1, 1); step("t3e");
        alu(5, 0, 0); step("t3f");
        nop(); #1;
        chk("t3.r0_fa", fa3, 0);
        chk("t3.r0_fb", fb3, 0);
        step("t3g");
        ld(0, 1); step("t3h");
        alu(5, 0, 0); #1;
        chk("t3.r0_nostall_pc", pc3, 1);
        chk("t3.r0_nostall_bub", bb3, 0);
        step("t3i");
        drain();

        ld(3, 1); step("t4a");
        drive(1, 3, 3, 1, 1, 6, 1, 0, 0, 1); #1;
        chk("t4.redir_pc", pc3, 1);
        chk("t4.redir_flush", fl3, 1);
        chk("t4.redir_bub", bb3, 1);
        step("t4b");
        chk("t4.cnt_hold", cnt3, 1);
        drive(1, 1, 2, 1, 1, 8, 1, 0, 0, 1); #1;
        chk("t4.ign_flush", fl3, 0);
        chk("t4.ign_bub", bb3, 0);
        chk("t4.ign_pc", pc3, 1);
        step("t4c");
        chk("t4.ign_enters", sv3[0], 1);
        drain();

        drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0); #1;
        chk("t5.jmp_flush", fl3, 1);
        chk("t5.jmp_pc", pc3, 1);
        step("t5a");
        chk("t5.jmp_enters", sv3[0], 1);
        ld(3, 1); step("t5b");
        drive(1, 3, 0, 1, 0, 0, 0, 0, 1, 0); #1;
        chk("t5.jmp_stall_flush", fl3, 0);
        chk("t5.jmp_stall_pc", pc3, 0);
        step("t5c");
        drain();

        base5 = c5;
        ld(3, 1); step("t6a");
        alu(6, 3, 3); #1; chk("t6.stall1", pc5, 0); step("t6b");
        #1; chk("t6.stall2", pc5, 0); step("t6c");
        #1;
        chk("t6.resume", pc5, 1);
        chk("t6.cnt2", cnt5, base5 + 2);
        step("t6d");
        nop(); #1;
        chk("t6.fa3", fa5, 3);
        chk("t6.fb3", fb5, 3);
        step("t6e");
        drain();

        force dut5.cnt = 32'hFFFF_FFFF;
        #1 release dut5.cnt;
        c5 = 32'hFFFF_FFFF;
        ld(3, 1); step("t6f");
        alu(6, 3, 3); step("t6g");
        step("t6h");
        chk("t6.sat", cnt5, 32'hFFFF_FFFF);
        drain();

        ld(3, 1); step("t6i");
        alu(6, 3, 3); #1;
        chk("t6.pre_rst_stall", pc3, 0);
        #2 reset = 1'b1;
        #1;
        chk("rst2.sv3", sv3, 0);
        chk("rst2.sv5", sv5, 0);
        chk("rst2.pc3", pc3, 1);
        chk("rst2.pc5", pc5, 1);
        chk("rst2.bub3", bb3, 0);
        chk("rst2.flush3", fl3, 0);
        chk("rst2.fa3", fa3, 0);
        @(negedge clk);
        clear_models();
        reset = 1'b0;

        repeat (400) begin
            drive($urandom_range(99) < 80, $urandom_range(7), $urandom_range(7),
                  1'($urandom_range(1)), 1'($urandom_range(1)), $urandom_range(7),
                  1'($urandom_range(1)), $urandom_range(99) < 30,
                  $urandom_range(99) < 10, $urandom_range(99) < 20);
            step("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
